// File: rtl/fp8_operand_sequencer.sv
// Feeds the FP8 adder: collects operand A then B from a byte stream, waits out
// the adder pipeline (or resolves infinities locally), then hands back one result.
module fp8_operand_sequencer #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] op_a_o,
  output logic [7:0] op_b_o,
  input  logic [7:0] adder_result_i,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       bypass_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {GET_A, GET_B, WAIT, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             bypass_q, bypass_d;
  logic             a_inf, b_inf;
  logic [7:0]       byp_val;

  // A is already latched when B arrives, so B is checked straight off the bus.
  always_comb begin
    a_inf = (op_a_q[6:3] == 4'hF);
    b_inf = (in_data_i[6:3] == 4'hF);
    if (a_inf && b_inf)
      byp_val = (op_a_q[7] == in_data_i[7]) ? {op_a_q[7], 4'hF, 3'b000} : 8'h00;
    else if (a_inf)
      byp_val = {op_a_q[7], 4'hF, 3'b000};
    else
      byp_val = {in_data_i[7], 4'hF, 3'b000};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    bypass_d    = bypass_q;
    case (state_q)
      GET_A: if (in_valid_i) begin
        op_a_d  = in_data_i;
        state_d = GET_B;
      end
      GET_B: if (in_valid_i) begin
        op_b_d = in_data_i;
        if (a_inf || b_inf) begin
          out_data_d = byp_val;
          bypass_d   = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          out_data_d = adder_result_i;
          bypass_d   = 1'b0;
          state_d    = DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // out_valid rises on the first edge spent in DONE, data is already stable
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= GET_A;
      cnt_q       <= '0;
      op_a_q      <= 8'h00;
      op_b_q      <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      bypass_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      bypass_q    <= bypass_d;
    end
  end

  assign in_ready_o  = (state_q == GET_A) || (state_q == GET_B);
  assign busy_o      = (state_q != GET_A);
  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign bypass_o    = bypass_q;

endmodule
